// File: rtl/serial_frame_rx.sv
// Async serial frame receiver: start, DW data bits MSB-first, optional parity, stop.
// Emits per-bit shift enables plus an assembled word with parity/framing flags.
module serial_frame_rx #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rx,
  output logic          o_bit_en,
  output logic          o_bit,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_parity_err,
  output logic          o_frame_err,
  output logic          o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DW + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [DW-1:0] sr_q;
  logic          par_q;
  logic          mis_q;

  logic smp_start;
  logic smp_data;
  logic smp_par;
  logic smp_stop;
  logic smp_any;
  logic cnt_run;
  logic data_last;

  // two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (smp_start) begin
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (smp_data && data_last) begin
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (smp_par) state_d = S_STOP;
      end
      S_STOP: begin
        if (smp_stop) begin
          state_d = rx_s ? S_IDLE : S_BRK;
        end
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    smp_start = 1'b0;
    smp_data  = 1'b0;
    smp_par   = 1'b0;
    smp_stop  = 1'b0;
    cnt_run   = 1'b0;
    unique case (state_q)
      S_START: begin
        cnt_run   = 1'b1;
        smp_start = (cnt_q == CNT_HALF);
      end
      S_DATA: begin
        cnt_run  = 1'b1;
        smp_data = (cnt_q == CNT_FULL);
      end
      S_PARITY: begin
        cnt_run = 1'b1;
        smp_par = (cnt_q == CNT_FULL);
      end
      S_STOP: begin
        cnt_run  = 1'b1;
        smp_stop = (cnt_q == CNT_FULL);
      end
      default: ;
    endcase
    smp_any   = smp_start | smp_data | smp_par | smp_stop;
    data_last = (bit_q == BIT_LAST);
    o_busy    = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (smp_any || state_d != state_q) begin
      cnt_q <= '0;
    end else if (cnt_run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= '0;
      sr_q  <= '0;
      par_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      if (smp_start) begin
        bit_q <= '0;
        par_q <= 1'b0;
        mis_q <= 1'b0;
      end
      if (smp_data) begin
        bit_q <= bit_q + 1'b1;
        sr_q  <= {sr_q[DW-2:0], rx_s};
        par_q <= par_q ^ rx_s;
      end
      if (smp_par) begin
        mis_q <= rx_s ^ par_q ^ PARITY_ODD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_bit_en     <= 1'b0;
      o_bit        <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_bit_en     <= smp_data;
      o_bit        <= smp_data & rx_s;
      o_valid      <= smp_stop & rx_s;
      o_parity_err <= smp_stop & rx_s & mis_q;
      o_frame_err  <= smp_stop & ~rx_s;
      if (smp_stop && rx_s) begin
        o_data <= sr_q;
      end
    end
  end

endmodule
